// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache request port between loads and committed-store drain.
// One-entry registered request slot under valid/ready; loads win unless stores starve or the SQ fills.
module dcache_port_arbiter #(
    parameter int SQ_SZ        = 8,
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(SQ_SZ + 1),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] retire_store_cnt,
    input  logic          sq_full,
    input  logic          sq_head_valid,
    input  logic [31:0]   sq_head_addr,
    input  logic [31:0]   sq_head_data,
    input  logic [3:0]    sq_head_byte_mask,
    output logic          sq_pop,
    input  logic          load_req_valid,
    input  logic [31:0]   load_req_addr,
    input  logic [3:0]    load_req_tag,
    output logic          load_req_ready,
    input  logic          flush,
    output logic          dcache_req_valid,
    output logic          dcache_req_is_store,
    output logic [31:0]   dcache_req_addr,
    output logic [31:0]   dcache_req_data,
    output logic [3:0]    dcache_req_byte_mask,
    output logic [3:0]    dcache_req_tag,
    input  logic          dcache_req_ready,
    output logic [CW-1:0] committed_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD_LD = 2'd1, HOLD_ST = 2'd2} state_t;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW:0]   CNT_MAX    = (CW + 1)'(SQ_SZ);

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          is_store_q, is_store_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    tag_q, tag_d;
    logic [CW-1:0] committed_q, committed_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          slot_free_s;
    logic          st_ok_s;
    logic          grant_st_s;
    logic          grant_ld_s;
    logic [CW:0]   cnt_sum_s;

    // Arbitration, next-state and payload selection
    always_comb begin
        slot_free_s = (state_q == IDLE) | (valid_q & dcache_req_ready);
        st_ok_s     = (committed_q != {CW{1'b0}}) & sq_head_valid;
        // Stores still drain during a flush; only the load grant is blocked
        grant_st_s  = slot_free_s & st_ok_s &
                      (sq_full | (starve_q >= STARVE_MAX) | ~load_req_valid);
        grant_ld_s  = slot_free_s & ~flush & ~grant_st_s & load_req_valid;

        state_d    = state_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        tag_d      = tag_q;
        starve_d   = starve_q;

        if (grant_st_s) begin
            state_d    = HOLD_ST;
            is_store_d = 1'b1;
            addr_d     = sq_head_addr;
            data_d     = sq_head_data;
            mask_d     = sq_head_byte_mask;
            tag_d      = 4'd0;
            starve_d   = {SW{1'b0}};
        end else if (grant_ld_s) begin
            state_d    = HOLD_LD;
            is_store_d = 1'b0;
            addr_d     = load_req_addr;
            data_d     = 32'd0;
            mask_d     = 4'b1111;
            tag_d      = load_req_tag;
            if (st_ok_s && (starve_q < STARVE_MAX)) begin
                starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                starve_d = starve_q;
            end
        end else if (slot_free_s) begin
            state_d = IDLE;
        end else if (flush && (state_q == HOLD_LD)) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        valid_d = (state_d != IDLE);

        cnt_sum_s = {1'b0, committed_q} + {1'b0, retire_store_cnt}
                  - {{CW{1'b0}}, grant_st_s};
        if (cnt_sum_s > CNT_MAX) begin
            committed_d = CNT_MAX[CW-1:0];
        end else begin
            committed_d = cnt_sum_s[CW-1:0];
        end

        sq_pop         = grant_st_s & ~reset;
        load_req_ready = grant_ld_s & ~reset;
    end

    // Request slot, drain counter and starvation counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            is_store_q  <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            mask_q      <= 4'd0;
            tag_q       <= 4'd0;
            committed_q <= {CW{1'b0}};
            starve_q    <= {SW{1'b0}};
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            tag_q       <= tag_d;
            committed_q <= committed_d;
            starve_q    <= starve_d;
        end
    end

    assign dcache_req_valid     = valid_q;
    assign dcache_req_is_store  = is_store_q;
    assign dcache_req_addr      = addr_q;
    assign dcache_req_data      = data_q;
    assign dcache_req_byte_mask = mask_q;
    assign dcache_req_tag       = tag_q;
    assign committed_cnt        = committed_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter (SQ_SZ=8, STARVE_LIMIT=4).
module tb_dcache_port_arbiter;

    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic [CW-1:0] retire_store_cnt;
    logic          sq_full;
    logic          sq_head_valid;
    logic [31:0]   sq_head_addr;
    logic [31:0]   sq_head_data;
    logic [3:0]    sq_head_byte_mask;
    logic          sq_pop;
    logic          load_req_valid;
    logic [31:0]   load_req_addr;
    logic [3:0]    load_req_tag;
    logic          load_req_ready;
    logic          flush;
    logic          dcache_req_valid;
    logic          dcache_req_is_store;
    logic [31:0]   dcache_req_addr;
    logic [31:0]   dcache_req_data;
    logic [3:0]    dcache_req_byte_mask;
    logic [3:0]    dcache_req_tag;
    logic          dcache_req_ready;
    logic [CW-1:0] committed_cnt;

    int total = 0;
    int bad   = 0;

    dcache_port_arbiter #(.SQ_SZ(8), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .retire_store_cnt(retire_store_cnt), .sq_full(sq_full),
        .sq_head_valid(sq_head_valid), .sq_head_addr(sq_head_addr),
        .sq_head_data(sq_head_data), .sq_head_byte_mask(sq_head_byte_mask),
        .sq_pop(sq_pop),
        .load_req_valid(load_req_valid), .load_req_addr(load_req_addr),
        .load_req_tag(load_req_tag), .load_req_ready(load_req_ready),
        .flush(flush),
        .dcache_req_valid(dcache_req_valid), .dcache_req_is_store(dcache_req_is_store),
        .dcache_req_addr(dcache_req_addr), .dcache_req_data(dcache_req_data),
        .dcache_req_byte_mask(dcache_req_byte_mask), .dcache_req_tag(dcache_req_tag),
        .dcache_req_ready(dcache_req_ready), .committed_cnt(committed_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Retire plus outstanding count may never exceed the store queue size
    always @(posedge clock) begin
        if (!reset && ({1'b0, committed_cnt} + {1'b0, retire_store_cnt} > 5'd8)) begin
            bad++;
            $display("FAIL retire_overflow got=%0d limit=8", committed_cnt + retire_store_cnt);
        end
    end

    // Advance one clock; registered outputs are settled on return
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; retire_store_cnt = 4'd0; sq_full = 1'b0; sq_head_valid = 1'b1;
        sq_head_addr = 32'h0; sq_head_data = 32'h0; sq_head_byte_mask = 4'h0;
        load_req_valid = 1'b0; load_req_addr = 32'h0; load_req_tag = 4'h0;
        flush = 1'b0; dcache_req_ready = 1'b1;
        tick(); tick();
        total++; if (dcache_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", dcache_req_valid); end
        total++; if (dcache_req_byte_mask !== 4'h0) begin bad++; $display("FAIL rst_mask got=%0h exp=0", dcache_req_byte_mask); end
        total++; if (committed_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", committed_cnt); end
        total++; if (sq_pop !== 1'b0 || load_req_ready !== 1'b0) begin bad++; $display("FAIL rst_hs got=%0b%0b exp=00", sq_pop, load_req_ready); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            total++;
            if (sq_pop !== 1'b0 || dcache_req_valid !== 1'b0 || committed_cnt !== 4'd0) begin
                bad++;
                $display("FAIL idle_quiet cyc=%0d got pop=%0b valid=%0b cnt=%0d exp 0/0/0", i, sq_pop, dcache_req_valid, committed_cnt);
            end
            tick();
        end
        sq_head_valid = 1'b0;
    endtask

    task automatic test_store_drain();
        retire_store_cnt = 4'd2;
        settle();
        total++; if (sq_pop !== 1'b0) begin bad++; $display("FAIL drain_no_early_pop got=%0b exp=0", sq_pop); end
        tick();
        retire_store_cnt = 4'd0; sq_head_valid = 1'b1;
        sq_head_addr = 32'h100; sq_head_data = 32'hAAAA_0001; sq_head_byte_mask = 4'b0011;
        settle();
        total++; if (committed_cnt !== 4'd2) begin bad++; $display("FAIL drain_cnt2 got=%0d exp=2", committed_cnt); end
        total++; if (sq_pop !== 1'b1) begin bad++; $display("FAIL drain_pop1 got=%0b exp=1", sq_pop); end
        tick();
        total++; if (committed_cnt !== 4'd1) begin bad++; $display("FAIL drain_cnt1 got=%0d exp=1", committed_cnt); end
        total++;
        if (dcache_req_valid !== 1'b1 || dcache_req_is_store !== 1'b1 || dcache_req_addr !== 32'h100 ||
            dcache_req_data !== 32'hAAAA_0001 || dcache_req_byte_mask !== 4'b0011 || dcache_req_tag !== 4'h0) begin
            bad++;
            $display("FAIL drain_req1 got v=%0b st=%0b a=%0h d=%0h m=%0h t=%0h exp 1/1/100/aaaa0001/3/0",
                     dcache_req_valid, dcache_req_is_store, dcache_req_addr, dcache_req_data, dcache_req_byte_mask, dcache_req_tag);
        end
        sq_head_addr = 32'h104; sq_head_data = 32'hAAAA_0002;
        settle();
        total++; if (sq_pop !== 1'b1) begin bad++; $display("FAIL drain_pop2 got=%0b exp=1", sq_pop); end
        tick();
        total++; if (dcache_req_addr !== 32'h104 || dcache_req_is_store !== 1'b1) begin bad++; $display("FAIL drain_req2 got a=%0h st=%0b exp 104/1", dcache_req_addr, dcache_req_is_store); end
        total++; if (committed_cnt !== 4'd0) begin bad++; $display("FAIL drain_cnt0 got=%0d exp=0", committed_cnt); end
        settle();
        total++; if (sq_pop !== 1'b0) begin bad++; $display("FAIL drain_no_pop3 got=%0b exp=0", sq_pop); end
        sq_head_valid = 1'b0;
        tick();
        total++; if (dcache_req_valid !== 1'b0) begin bad++; $display("FAIL drain_idle got=%0b exp=0", dcache_req_valid); end
    endtask

    task automatic test_starvation();
        sq_head_valid = 1'b1; sq_head_addr = 32'h180; sq_head_data = 32'h5555_0000; sq_head_byte_mask = 4'b1111;
        load_req_valid = 1'b1; load_req_addr = 32'h800; load_req_tag = 4'd3;
        retire_store_cnt = 4'd1;
        settle();
        total++; if (load_req_ready !== 1'b1) begin bad++; $display("FAIL starve_ld0 got=%0b exp=1", load_req_ready); end
        tick();
        retire_store_cnt = 4'd0;
        total++;
        if (dcache_req_is_store !== 1'b0 || dcache_req_data !== 32'h0 || dcache_req_byte_mask !== 4'b1111 || dcache_req_tag !== 4'd3) begin
            bad++;
            $display("FAIL starve_ldpay got st=%0b d=%0h m=%0h t=%0h exp 0/0/f/3", dcache_req_is_store, dcache_req_data, dcache_req_byte_mask, dcache_req_tag);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                settle();
                total++;
                if (load_req_ready !== 1'b1 || sq_pop !== 1'b0) begin
                    bad++;
                    $display("FAIL starve_ld round=%0d i=%0d got rdy=%0b pop=%0b exp 1/0", r, i, load_req_ready, sq_pop);
                end
                tick();
            end
            if (r == 0) retire_store_cnt = 4'd1;
            settle();
            total++;
            if (sq_pop !== 1'b1 || load_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL starve_st round=%0d got pop=%0b rdy=%0b exp 1/0", r, sq_pop, load_req_ready);
            end
            tick();
            retire_store_cnt = 4'd0;
            if (r == 0) begin
                total++; if (committed_cnt !== 4'd1) begin bad++; $display("FAIL retire_pop_cnt got=%0d exp=1", committed_cnt); end
            end
        end
        load_req_valid = 1'b0;
        total++; if (dcache_req_is_store !== 1'b1 || committed_cnt !== 4'd0) begin bad++; $display("FAIL starve_end got st=%0b cnt=%0d exp 1/0", dcache_req_is_store, committed_cnt); end
        sq_head_valid = 1'b0;
    endtask

    task automatic test_sq_full();
        retire_store_cnt = 4'd1;
        tick();
        retire_store_cnt = 4'd0; sq_head_valid = 1'b1; sq_head_addr = 32'h1C0;
        sq_full = 1'b1; load_req_valid = 1'b1; load_req_addr = 32'h900; load_req_tag = 4'd7;
        settle();
        total++; if (sq_pop !== 1'b1 || load_req_ready !== 1'b0) begin bad++; $display("FAIL sqfull_win got pop=%0b rdy=%0b exp 1/0", sq_pop, load_req_ready); end
        tick();
        sq_full = 1'b0; sq_head_valid = 1'b0;
        total++; if (dcache_req_is_store !== 1'b1 || dcache_req_addr !== 32'h1C0) begin bad++; $display("FAIL sqfull_req got st=%0b a=%0h exp 1/1c0", dcache_req_is_store, dcache_req_addr); end
    endtask

    task automatic test_stall();
        load_req_valid = 1'b1; load_req_addr = 32'h200; load_req_tag = 4'd5;
        settle();
        total++; if (load_req_ready !== 1'b1) begin bad++; $display("FAIL stall_grant got=%0b exp=1", load_req_ready); end
        tick();
        dcache_req_ready = 1'b0; load_req_addr = 32'h300; load_req_tag = 4'd6;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (load_req_ready !== 1'b0 || dcache_req_valid !== 1'b1 || dcache_req_addr !== 32'h200 ||
                dcache_req_tag !== 4'd5 || dcache_req_is_store !== 1'b0 || dcache_req_byte_mask !== 4'b1111) begin
                bad++;
                $display("FAIL stall_hold i=%0d got rdy=%0b v=%0b a=%0h t=%0h exp 0/1/200/5", i, load_req_ready, dcache_req_valid, dcache_req_addr, dcache_req_tag);
            end
            tick();
        end
        dcache_req_ready = 1'b1;
        settle();
        total++; if (load_req_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", load_req_ready); end
        tick();
        total++; if (dcache_req_addr !== 32'h300 || dcache_req_tag !== 4'd6) begin bad++; $display("FAIL back_to_back got a=%0h t=%0h exp 300/6", dcache_req_addr, dcache_req_tag); end
    endtask

    task automatic test_flush();
        dcache_req_ready = 1'b0; flush = 1'b1;
        settle();
        total++; if (load_req_ready !== 1'b0) begin bad++; $display("FAIL flush_no_ld got=%0b exp=0", load_req_ready); end
        tick();
        flush = 1'b0; load_req_valid = 1'b0;
        total++; if (dcache_req_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%0b exp=0", dcache_req_valid); end
        retire_store_cnt = 4'd1;
        tick();
        retire_store_cnt = 4'd0; sq_head_valid = 1'b1; sq_head_addr = 32'h400;
        settle();
        total++; if (sq_pop !== 1'b1) begin bad++; $display("FAIL flush_st_grant got=%0b exp=1", sq_pop); end
        tick();
        sq_head_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (dcache_req_valid !== 1'b1 || dcache_req_is_store !== 1'b1 || dcache_req_addr !== 32'h400) begin bad++; $display("FAIL flush_st_keep got v=%0b st=%0b a=%0h exp 1/1/400", dcache_req_valid, dcache_req_is_store, dcache_req_addr); end
        dcache_req_ready = 1'b1;
        tick();
        total++; if (dcache_req_valid !== 1'b0) begin bad++; $display("FAIL flush_st_done got=%0b exp=0", dcache_req_valid); end
    endtask

    task automatic test_reset_mid();
        load_req_valid = 1'b1; load_req_addr = 32'h500; load_req_tag = 4'd9;
        tick();
        load_req_valid = 1'b0; dcache_req_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; dcache_req_ready = 1'b1;
        total++; if (dcache_req_valid !== 1'b0 || dcache_req_byte_mask !== 4'h0 || dcache_req_addr !== 32'h0) begin bad++; $display("FAIL rst_mid got v=%0b m=%0h a=%0h exp 0/0/0", dcache_req_valid, dcache_req_byte_mask, dcache_req_addr); end
    endtask

    initial begin
        test_reset();
        test_store_drain();
        test_starvation();
        test_sq_full();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
